// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I MEM-stage load/store controller.
// Sits between the EX/MEM register and a word-only data memory whose read port
// is combinational. Sub-word stores use read-modify-write, and sub-word loads
// are lane-selected and then sign- or zero-extended. Every output is registered.
module lsu_mem_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_is_load,
    input  logic             i_is_store,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic [WIDTH-1:0] i_mem_rdata,
    output logic [WIDTH-1:0] o_load_data,
    output logic             o_load_valid,
    output logic             o_store_done,
    output logic             o_fault
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Request fields, captured on acceptance.
    logic [WIDTH-1:0] r_addr;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_wdata;

    // Registered outputs.
    logic             r_ready;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;
    logic [WIDTH-1:0] r_load_data;
    logic             r_load_valid;
    logic             r_store_done;
    logic             r_fault;

    // Next values for the output registers.
    logic             w_ready;
    logic             w_mem_read;
    logic             w_mem_write;
    logic [WIDTH-1:0] w_mem_addr;
    logic [WIDTH-1:0] w_mem_wdata;
    logic [WIDTH-1:0] w_load_data;
    logic             w_load_valid;
    logic             w_store_done;
    logic             w_fault;

    logic             w_accept;
    logic             w_illegal;
    logic             w_misaligned;
    logic             w_bad_f3;
    logic [WIDTH-1:0] w_req_addr;
    logic [BYTE_W-1:0] w_lane_b;
    logic [HALF_W-1:0] w_lane_h;
    logic [WIDTH-1:0] w_extended;
    logic [WIDTH-1:0] w_merged;

    assign w_accept = (r_state == S_IDLE) && i_valid;

    // Decode the incoming request for faults: direction, funct3 legality and alignment.
    always_comb begin
        w_bad_f3     = 1'b0;
        w_misaligned = 1'b0;
        case (i_funct3)
            F3_B:         w_bad_f3 = 1'b0;
            F3_H:         w_misaligned = i_addr[0];
            F3_W:         w_misaligned = (i_addr[1:0] != 2'b00);
            F3_BU:        w_bad_f3 = i_is_store;
            F3_HU: begin
                w_bad_f3     = i_is_store;
                w_misaligned = i_addr[0];
            end
            default:      w_bad_f3 = 1'b1;
        endcase
        w_illegal = (i_is_load == i_is_store) || w_bad_f3 || w_misaligned;
    end

    // Address source: the live request while idle, else the captured one.
    assign w_req_addr = (r_state == S_IDLE) ? i_addr : r_addr;

    // Load lane select and extension from the combinational memory read data.
    always_comb begin
        w_lane_b = BYTE_W'(i_mem_rdata >> {r_addr[1:0], 3'b000});
        w_lane_h = HALF_W'(i_mem_rdata >> {r_addr[1], 4'b0000});
        case (r_funct3)
            F3_B:    w_extended = {{(WIDTH-BYTE_W){w_lane_b[BYTE_W-1]}}, w_lane_b};
            F3_BU:   w_extended = {{(WIDTH-BYTE_W){1'b0}}, w_lane_b};
            F3_H:    w_extended = {{(WIDTH-HALF_W){w_lane_h[HALF_W-1]}}, w_lane_h};
            F3_HU:   w_extended = {{(WIDTH-HALF_W){1'b0}}, w_lane_h};
            default: w_extended = i_mem_rdata;
        endcase
    end

    // Sub-word store merge: drop the new byte/half into its lane of the old word.
    always_comb begin
        w_merged = i_mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_addr[1:0], 3'b000} +: BYTE_W] = r_wdata[BYTE_W-1:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: HALF_W] = r_wdata[HALF_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_illegal) begin
                    if (i_is_load) begin
                        w_next = S_RD;
                    end else if (i_funct3 == F3_W) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RMW_RD;
                    end
                end
            end
            S_RD:     w_next = S_IDLE;
            S_WR:     w_next = S_IDLE;
            S_RMW_RD: w_next = S_RMW_WR;
            S_RMW_WR: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed by the state being entered.
    always_comb begin
        w_ready      = (w_next == S_IDLE);
        w_mem_read   = (w_next == S_RD) || (w_next == S_RMW_RD);
        w_mem_write  = (w_next == S_WR) || (w_next == S_RMW_WR);
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_load_data  = r_load_data;
        w_load_valid = (r_state == S_RD);
        w_store_done = (r_state == S_WR) || (r_state == S_RMW_WR);
        w_fault      = w_accept && w_illegal;
        if (w_next != S_IDLE) begin
            w_mem_addr = {w_req_addr[WIDTH-1:2], 2'b00};
        end
        if (w_next == S_WR) begin
            w_mem_wdata = i_wdata;
        end else if (w_next == S_RMW_WR) begin
            w_mem_wdata = w_merged;
        end
        if (r_state == S_RD) begin
            w_load_data = w_extended;
        end
    end

    // Output and request-capture registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready      <= 1'b1;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_store_done <= 1'b0;
            r_fault      <= 1'b0;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_wdata      <= '0;
        end else begin
            r_ready      <= w_ready;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_load_data  <= w_load_data;
            r_load_valid <= w_load_valid;
            r_store_done <= w_store_done;
            r_fault      <= w_fault;
            if (w_accept) begin
                r_addr   <= i_addr;
                r_funct3 <= i_funct3;
                r_wdata  <= i_wdata;
            end
        end
    end

    assign o_ready      = r_ready;
    assign o_mem_read   = r_mem_read;
    assign o_mem_write  = r_mem_write;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_load_data  = r_load_data;
    assign o_load_valid = r_load_valid;
    assign o_store_done = r_store_done;
    assign o_fault      = r_fault;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl with a word-addressed memory model.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        store_done;
    logic        fault;

    int checks;
    int errors;
    int wr_count;

    logic [31:0] mem [0:4095];

    lsu_mem_ctrl #(.WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_is_load    (is_load),
        .i_is_store   (is_store),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_load_data  (load_data),
        .o_load_valid (load_valid),
        .o_store_done (store_done),
        .o_fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read, clocked-write data memory.
    assign mem_rdata = mem[mem_addr[13:2]];
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[13:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        valid    = 1'b1;
        is_load  = ld;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = d;
    endtask

    // Load accepted now (cycle N): read in N+1, result in N+2.
    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        tick();
        valid = 1'b0;
        chk({tag, " rd"}, 32'(mem_read), 32'd1);
        chk({tag, " rd_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, " ready_lo"}, 32'(ready), 32'd0);
        tick();
        chk({tag, " valid"}, 32'(load_valid), 32'd1);
        chk({tag, " data"}, load_data, exp);
        chk({tag, " rd_off"}, 32'(mem_read), 32'd0);
    endtask

    task automatic do_fault(input string tag, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a);
        drive(ld, st, f3, a, 32'h0);
        tick();
        valid = 1'b0;
        chk({tag, " fault"}, 32'(fault), 32'd1);
        chk({tag, " no_access"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({tag, " ready"}, 32'(ready), 32'd1);
        tick();
        chk({tag, " fault_off"}, 32'(fault), 32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wr_count = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h400] = 32'hDEADBEEF;
        rst_n    = 1'b0;
        valid    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        funct3   = 3'b000;
        addr     = 32'h0;
        wdata    = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset values.
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst addr", mem_addr, 32'h0);
        chk("rst pulses", {29'd0, load_valid, store_done, fault}, 32'd0);
        chk("rst ldata", load_data, 32'h0);

        // Word and sub-word loads.
        do_load("LW", 3'b010, 32'h1000, 32'hDEADBEEF);
        tick();
        chk("LW pulse_off", 32'(load_valid), 32'd0);
        chk("LW hold", load_data, 32'hDEADBEEF);
        do_load("LB", 3'b000, 32'h1003, 32'hFFFFFFDE);
        do_load("LBU", 3'b100, 32'h1003, 32'h000000DE);
        do_load("LH", 3'b001, 32'h1002, 32'hFFFFDEAD);
        do_load("LHU", 3'b101, 32'h1000, 32'h0000BEEF);
        do_load("LB1", 3'b000, 32'h1001, 32'hFFFFFFBE);
        tick();

        // Byte store via read-modify-write.
        drive(1'b0, 1'b1, 3'b000, 32'h1001, 32'h123456AA);
        tick();
        valid = 1'b0;
        chk("SB rd", {30'd0, mem_read, mem_write}, 32'd2);
        chk("SB rd_addr", mem_addr, 32'h1000);
        chk("SB ready1", 32'(ready), 32'd0);
        tick();
        chk("SB wr", {30'd0, mem_read, mem_write}, 32'd1);
        chk("SB wdata", mem_wdata, 32'hDEADAAEF);
        chk("SB wr_addr", mem_addr, 32'h1000);
        chk("SB ready2", 32'(ready), 32'd0);
        chk("SB done_early", 32'(store_done), 32'd0);
        tick();
        chk("SB done", 32'(store_done), 32'd1);
        chk("SB ready3", 32'(ready), 32'd1);
        chk("SB mem", mem[12'h400], 32'hDEADAAEF);
        chk("SB idle_addr", mem_addr, 32'h0);
        tick();

        // Half store into the upper lane.
        drive(1'b0, 1'b1, 3'b001, 32'h1002, 32'hFFFF5566);
        tick();
        valid = 1'b0;
        tick();
        chk("SH wdata", mem_wdata, 32'h5566AAEF);
        tick();
        chk("SH done", 32'(store_done), 32'd1);
        tick();

        // Faults: misaligned, illegal direction, reserved or load-only funct3.
        do_fault("F_LW", 1'b1, 1'b0, 3'b010, 32'h1002);
        do_fault("F_SH", 1'b0, 1'b1, 3'b001, 32'h1001);
        do_fault("F_LDST", 1'b1, 1'b1, 3'b010, 32'h1000);
        do_fault("F_NONE", 1'b0, 1'b0, 3'b010, 32'h1000);
        do_fault("F_SBU", 1'b0, 1'b1, 3'b100, 32'h1000);
        do_fault("F_RSV", 1'b1, 1'b0, 3'b011, 32'h1000);

        // Reset while an SB is in its read phase: no write may follow.
        wr_count = 0;
        drive(1'b0, 1'b1, 3'b000, 32'h1000, 32'h00000077);
        tick();
        chk("RST rmw_rd", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        valid = 1'b0;
        chk("RST ready", 32'(ready), 32'd1);
        chk("RST rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("RST addr", mem_addr, 32'h0);
        chk("RST pulses", {29'd0, load_valid, store_done, fault}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("RST no_write", 32'(wr_count), 32'd0);
        chk("RST mem", mem[12'h400], 32'h5566AAEF);
        chk("RST no_done", 32'(store_done), 32'd0);
        do_load("RST LW", 3'b010, 32'h1000, 32'h5566AAEF);
        tick();

        // Back-to-back SW then LW with i_valid held throughout.
        wr_count = 0;
        drive(1'b0, 1'b1, 3'b010, 32'h2000, 32'h11223344);
        tick();
        chk("B2B wr", {30'd0, mem_read, mem_write}, 32'd1);
        chk("B2B wdata", mem_wdata, 32'h11223344);
        drive(1'b1, 1'b0, 3'b010, 32'h2000, 32'h0);
        tick();
        chk("B2B done", 32'(store_done), 32'd1);
        chk("B2B ready", 32'(ready), 32'd1);
        tick();
        valid = 1'b0;
        chk("B2B rd", {30'd0, mem_read, mem_write}, 32'd2);
        chk("B2B rd_addr", mem_addr, 32'h2000);
        chk("B2B done_off", 32'(store_done), 32'd0);
        tick();
        chk("B2B lvalid", 32'(load_valid), 32'd1);
        chk("B2B ldata", load_data, 32'h11223344);
        tick();
        chk("B2B lvalid_off", 32'(load_valid), 32'd0);
        chk("B2B no_dup", {30'd0, mem_read, mem_write}, 32'd0);
        chk("B2B one_write", 32'(wr_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
